// File: rtl/nkmd_dai_pkg.sv
// nkmd_dai_pkg: shared constants and address decode for the DAI receive
// block. The optional overflow behaviour is selected with the macro
// NKMD_DAI_RX_OVF_EN (see nkmd_dai_rx_ring_ctl / nkmd_dai_rx_mc).
package nkmd_dai_pkg;

   // R-bus regions (addr_i[15:12])
   localparam logic [3:0] NKMD_DAI_REG_REGION    = 4'hd;
   localparam logic [3:0] NKMD_DAI_RX_BUF_REGION = 4'hf;

   // Register offsets inside the register region (addr_i[7:0])
   localparam logic [7:0] NKMD_DAI_RX_UNREAD = 8'h00;
   localparam logic [7:0] NKMD_DAI_RX_STATUS = 8'h02;

   // Decoded view of the low half of an R-bus address
   typedef struct packed {
      logic [3:0] region;
      logic [3:0] ch;
      logic [7:0] off;
   } nkmd_dai_addr_t;

   function automatic nkmd_dai_addr_t nkmd_dai_decode(input logic [15:0] addr);
      return nkmd_dai_addr_t'(addr);
   endfunction

endpackage

// File: rtl/nkmd_dai_rx_ring_ctl.sv
// nkmd_dai_rx_ring_ctl: write pointer, read pointer, unread count and sticky
// overflow flag for one receive channel. Sample storage lives in the parent.
// With NKMD_DAI_RX_OVF_EN defined, a sample to a full ring overwrites the
// oldest entry and sets the overflow flag; otherwise it is dropped.
module nkmd_dai_rx_ring_ctl #(
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_ack,      // sample arriving for this channel
   input  logic                  i_cons,     // consume request for this channel
   input  logic [DEPTH_LOG2:0]   i_cons_n,   // requested consume amount
   input  logic                  i_ovf_clr,  // clear sticky overflow flag
   output logic                  o_wr_en,    // store the sample at o_wp this cycle
   output logic [DEPTH_LOG2-1:0] o_wp,
   output logic [DEPTH_LOG2-1:0] o_rp,
   output logic [DEPTH_LOG2:0]   o_cnt,
   output logic                  o_ovf
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

   logic [DEPTH_LOG2-1:0] r_wp;
   logic [DEPTH_LOG2-1:0] r_rp;
   logic [DEPTH_LOG2:0]   r_cnt;

   logic [DEPTH_LOG2:0]   w_n;
   logic                  w_cons_any;
   logic                  w_full;
   logic                  w_push;
   logic                  w_ovr;
   logic                  w_adv;
   logic [DEPTH_LOG2-1:0] w_wp_nxt;
   logic [DEPTH_LOG2-1:0] w_rp_nxt;
   logic [DEPTH_LOG2:0]   w_cnt_nxt;

   // Clamp the consume to the pre-cycle count, then derive pointer/count updates
   always_comb begin
      w_n = '0;
      if (i_cons) begin
         w_n = (i_cons_n < r_cnt) ? i_cons_n : r_cnt;
      end
      w_cons_any = (w_n != '0);
      w_full     = (r_cnt == CNT_FULL);
      // A consume in the same cycle frees space, so a full ring still accepts
      w_push     = i_ack && (!w_full || w_cons_any);
`ifdef NKMD_DAI_RX_OVF_EN
      w_ovr      = i_ack && w_full && !w_cons_any;
`else
      w_ovr      = 1'b0;
`endif
      w_adv      = w_push || w_ovr;
      w_wp_nxt   = r_wp + DEPTH_LOG2'(w_adv);
      w_rp_nxt   = r_rp + w_n[DEPTH_LOG2-1:0] + DEPTH_LOG2'(w_ovr);
      w_cnt_nxt  = r_cnt - w_n + (DEPTH_LOG2+1)'(w_push);
   end

   // Pointer and count registers, cleared to the empty state by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= w_wp_nxt;
         r_rp  <= w_rp_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

`ifdef NKMD_DAI_RX_OVF_EN
   logic r_ovf;

   // Sticky overflow flag; a set in the same cycle as a clear wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_ovr) begin
         r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign o_ovf = r_ovf;
`else
   logic w_unused_clr;
   assign w_unused_clr = i_ovf_clr;
   assign o_ovf        = 1'b0;
`endif

   assign o_wr_en = w_adv;
   assign o_wp    = r_wp;
   assign o_rp    = r_rp;
   assign o_cnt   = r_cnt;

endmodule

// File: rtl/nkmd_dai_rx_mc.sv
// nkmd_dai_rx_mc: multi-channel DAI receive buffer with an R-bus register
// interface. Each channel owns a DEPTH-entry ring inside one shared sample
// array indexed {ch, ptr}. Optional overflow handling: NKMD_DAI_RX_OVF_EN.
//
// Handshake: rx_ack_i is a one-cycle valid strobe qualifying rx_data_i and
// rx_ch_i. There is no ready; the block always takes the strobe. Samples to a
// channel >= NCH, or arriving during reset, are discarded; a sample to a full
// channel overwrites the oldest entry (overflow build) or is dropped.
module nkmd_dai_rx_mc
   import nkmd_dai_pkg::*;
#(
   parameter  int DATA_W     = 24,
   parameter  int DEPTH_LOG2 = 6,
   parameter  int NCH        = 2,
   localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rx_data_i,
   input  logic [CH_W-1:0]   rx_ch_i,
   input  logic              rx_ack_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       data_o,
   input  logic [31:0]       addr_i,
   input  logic              we_i
);

   localparam int IDX_W  = CH_W + DEPTH_LOG2;
   localparam int RING_N = 1 << IDX_W;
   localparam logic [4:0]    NCH_A  = 5'(NCH);
   localparam logic [CH_W:0] NCH_RX = (CH_W+1)'(NCH);

   // Shared sample storage; intentionally not reset
   logic [DATA_W-1:0] r_ring [RING_N];

   logic [31:0] r_data_o;

   nkmd_dai_addr_t        w_addr;
   logic                  w_addr_ch_ok;
   logic [CH_W-1:0]       w_addr_ch;
   logic                  w_rx_go;
   logic                  w_reg_wr;
   logic [NCH-1:0]        w_wr_en;
   logic [DEPTH_LOG2-1:0] w_wp  [NCH];
   logic [DEPTH_LOG2-1:0] w_rp  [NCH];
   logic [DEPTH_LOG2:0]   w_cnt [NCH];
   logic [NCH-1:0]        w_ovf;
   logic [DEPTH_LOG2-1:0] w_buf_ptr;
   logic [31:0]           w_rd_data;
   logic                  w_unused_bits;

   assign w_addr        = nkmd_dai_decode(addr_i[15:0]);
   assign w_addr_ch_ok  = ({1'b0, w_addr.ch} < NCH_A);
   assign w_addr_ch     = w_addr.ch[CH_W-1:0];
   assign w_rx_go       = rx_ack_i && ({1'b0, rx_ch_i} < NCH_RX);
   assign w_reg_wr      = we_i && (w_addr.region == NKMD_DAI_REG_REGION) && w_addr_ch_ok;
   assign w_unused_bits = ^{addr_i[31:16], data_i[31:DEPTH_LOG2+1]};

   // One pointer/count controller per channel
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic w_ch_sel;
      assign w_ch_sel = (w_addr_ch == CH_W'(g));

      nkmd_dai_rx_ring_ctl #(
         .DEPTH_LOG2 (DEPTH_LOG2)
      ) u_ctl (
         .clk       (clk),
         .rst       (rst),
         .i_ack     (w_rx_go && (rx_ch_i == CH_W'(g))),
         .i_cons    (w_reg_wr && w_ch_sel && (w_addr.off == NKMD_DAI_RX_UNREAD)),
         .i_cons_n  (data_i[DEPTH_LOG2:0]),
         .i_ovf_clr (w_reg_wr && w_ch_sel && (w_addr.off == NKMD_DAI_RX_STATUS) && data_i[0]),
         .o_wr_en   (w_wr_en[g]),
         .o_wp      (w_wp[g]),
         .o_rp      (w_rp[g]),
         .o_cnt     (w_cnt[g]),
         .o_ovf     (w_ovf[g])
      );
   end

   // Store an accepted sample at its channel's write pointer
   always_ff @(posedge clk) begin
      if (!rst && w_rx_go && w_wr_en[rx_ch_i]) begin
         r_ring[{rx_ch_i, w_wp[rx_ch_i]}] <= rx_data_i;
      end
   end

   // Read decode: anything unmapped or out of channel range reads zero
   always_comb begin
      w_rd_data = '0;
      w_buf_ptr = w_rp[w_addr_ch] + w_addr.off[DEPTH_LOG2-1:0];
      if (w_addr_ch_ok) begin
         if (w_addr.region == NKMD_DAI_REG_REGION) begin
            if (w_addr.off == NKMD_DAI_RX_UNREAD) begin
               w_rd_data[DEPTH_LOG2:0] = w_cnt[w_addr_ch];
            end else if (w_addr.off == NKMD_DAI_RX_STATUS) begin
               w_rd_data[0] = w_ovf[w_addr_ch];
            end
         end else if (w_addr.region == NKMD_DAI_RX_BUF_REGION) begin
            w_rd_data[DATA_W-1:0] = r_ring[{w_addr_ch, w_buf_ptr}];
         end
      end
   end

   // Registered read data, one cycle behind addr_i
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_o <= '0;
      end else begin
         r_data_o <= w_rd_data;
      end
   end

   assign data_o = r_data_o;

endmodule

// File: tb/tb_nkmd_dai_rx_mc.sv
// tb_nkmd_dai_rx_mc: directed self-checking bench for nkmd_dai_rx_mc with
// default parameters (DATA_W=24, DEPTH_LOG2=6, NCH=2). Expectations that
// differ with NKMD_DAI_RX_OVF_EN are selected with the same macro.
module tb_nkmd_dai_rx_mc;

  localparam int DATA_W     = 24;
  localparam int DEPTH_LOG2 = 6;
  localparam int NCH        = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] rx_data_i;
  logic [0:0]        rx_ch_i;
  logic              rx_ack_i;
  logic [31:0]       data_i;
  logic [31:0]       data_o;
  logic [31:0]       addr_i;
  logic              we_i;

  int compared   = 0;
  int mismatched = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    rst       = 1'b1;
    rx_data_i = '0;
    rx_ch_i   = '0;
    rx_ack_i  = 1'b0;
    data_i    = '0;
    addr_i    = '0;
    we_i      = 1'b0;
  end

  nkmd_dai_rx_mc #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .NCH        (NCH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data_i (rx_data_i),
    .rx_ch_i   (rx_ch_i),
    .rx_ack_i  (rx_ack_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .addr_i    (addr_i),
    .we_i      (we_i)
  );

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] ad(input logic [3:0] rg, input logic [3:0] ch, input logic [7:0] off);
    return {16'h0000, rg, ch, off};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_ack(input logic [0:0] ch, input logic [DATA_W-1:0] d);
    @(negedge clk);
    rx_ack_i  = 1'b1;
    rx_ch_i   = ch;
    rx_data_i = d;
    @(posedge clk);
    #1 rx_ack_i = 1'b0;
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_i = a;
    data_i = d;
    we_i   = 1'b1;
    @(posedge clk);
    #1 we_i = 1'b0;
  endtask

  task automatic do_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_i = a;
    we_i   = 1'b0;
    @(posedge clk);
    #1 d = data_o;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] got;
    rst = 1'b1;
    // a sample strobed while in reset must be discarded
    @(negedge clk);
    rx_ack_i = 1'b1; rx_ch_i = 1'b0; rx_data_i = 24'hdead;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (data_o !== 32'h0) begin mismatched++; $display("FAIL rst_data_o: got %h exp %h", data_o, 32'h0); end
    @(negedge clk);
    rx_ack_i = 1'b0;
    rst      = 1'b0;
    do_rd(ad(4'hd, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'h0) begin mismatched++; $display("FAIL rst_cnt0: got %h exp %h", got, 32'h0); end
    do_rd(ad(4'hd, 4'h1, 8'h00), got);
    compared++;
    if (got !== 32'h0) begin mismatched++; $display("FAIL rst_cnt1: got %h exp %h", got, 32'h0); end
  endtask

  task automatic test_basic();
    logic [31:0] got;
    do_ack(1'b1, 24'h000011);
    do_ack(1'b1, 24'h000022);
    do_ack(1'b1, 24'h000033);
    do_rd(ad(4'hd, 4'h1, 8'h00), got);
    compared++;
    if (got !== 32'h3) begin mismatched++; $display("FAIL basic_cnt1: got %h exp %h", got, 32'h3); end
    do_rd(ad(4'hf, 4'h1, 8'h00), got);
    compared++;
    if (got !== 32'h11) begin mismatched++; $display("FAIL basic_buf0: got %h exp %h", got, 32'h11); end
    do_rd(ad(4'hf, 4'h1, 8'h01), got);
    compared++;
    if (got !== 32'h22) begin mismatched++; $display("FAIL basic_buf1: got %h exp %h", got, 32'h22); end
    do_rd(ad(4'hf, 4'h1, 8'h02), got);
    compared++;
    if (got !== 32'h33) begin mismatched++; $display("FAIL basic_buf2: got %h exp %h", got, 32'h33); end
    do_rd(ad(4'hd, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'h0) begin mismatched++; $display("FAIL basic_cnt0: got %h exp %h", got, 32'h0); end
  endtask

  task automatic test_consume();
    logic [31:0] got;
    do_wr(ad(4'hd, 4'h1, 8'h00), 32'd2);
    do_rd(ad(4'hd, 4'h1, 8'h00), got);
    compared++;
    if (got !== 32'h1) begin mismatched++; $display("FAIL cons_cnt: got %h exp %h", got, 32'h1); end
    do_rd(ad(4'hf, 4'h1, 8'h00), got);
    compared++;
    if (got !== 32'h33) begin mismatched++; $display("FAIL cons_buf: got %h exp %h", got, 32'h33); end
  endtask

  task automatic test_clamp();
    logic [31:0] got;
    do_wr(ad(4'hd, 4'h1, 8'h00), 32'd5);
    do_rd(ad(4'hd, 4'h1, 8'h00), got);
    compared++;
    if (got !== 32'h0) begin mismatched++; $display("FAIL clamp_cnt: got %h exp %h", got, 32'h0); end
    // rp moved by exactly one, so the next sample becomes the oldest
    do_ack(1'b1, 24'h000044);
    do_rd(ad(4'hf, 4'h1, 8'h00), got);
    compared++;
    if (got !== 32'h44) begin mismatched++; $display("FAIL clamp_rp: got %h exp %h", got, 32'h44); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] got;
    for (int i = 0; i < 4; i++) do_ack(1'b0, 24'h0000a0 + 24'(i));
    // consume 1 and ack on ch0 in the same cycle
    @(negedge clk);
    rx_ack_i = 1'b1; rx_ch_i = 1'b0; rx_data_i = 24'h0000a4;
    addr_i = ad(4'hd, 4'h0, 8'h00); data_i = 32'd1; we_i = 1'b1;
    @(posedge clk);
    #1 rx_ack_i = 1'b0; we_i = 1'b0;
    do_rd(ad(4'hd, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'h4) begin mismatched++; $display("FAIL same_cnt: got %h exp %h", got, 32'h4); end
    do_rd(ad(4'hf, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'ha1) begin mismatched++; $display("FAIL same_buf0: got %h exp %h", got, 32'ha1); end
    do_rd(ad(4'hf, 4'h0, 8'h03), got);
    compared++;
    if (got !== 32'ha4) begin mismatched++; $display("FAIL same_buf3: got %h exp %h", got, 32'ha4); end
    // consume on ch0 and ack on ch1 in the same cycle
    @(negedge clk);
    rx_ack_i = 1'b1; rx_ch_i = 1'b1; rx_data_i = 24'h000055;
    addr_i = ad(4'hd, 4'h0, 8'h00); data_i = 32'd1; we_i = 1'b1;
    @(posedge clk);
    #1 rx_ack_i = 1'b0; we_i = 1'b0;
    do_rd(ad(4'hd, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'h3) begin mismatched++; $display("FAIL diff_cnt0: got %h exp %h", got, 32'h3); end
    do_rd(ad(4'hd, 4'h1, 8'h00), got);
    compared++;
    if (got !== 32'h2) begin mismatched++; $display("FAIL diff_cnt1: got %h exp %h", got, 32'h2); end
    do_rd(ad(4'hf, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'ha2) begin mismatched++; $display("FAIL diff_buf0: got %h exp %h", got, 32'ha2); end
    do_rd(ad(4'hf, 4'h1, 8'h01), got);
    compared++;
    if (got !== 32'h55) begin mismatched++; $display("FAIL diff_buf1: got %h exp %h", got, 32'h55); end
  endtask

  task automatic test_full();
    logic [31:0] got;
    do_reset();
    for (int i = 0; i < 65; i++) do_ack(1'b0, 24'(i));
    do_rd(ad(4'hd, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'd64) begin mismatched++; $display("FAIL full_cnt: got %h exp %h", got, 32'd64); end
`ifdef NKMD_DAI_RX_OVF_EN
    do_rd(ad(4'hf, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'd1) begin mismatched++; $display("FAIL ovf_oldest: got %h exp %h", got, 32'd1); end
    do_rd(ad(4'hf, 4'h0, 8'h3f), got);
    compared++;
    if (got !== 32'd64) begin mismatched++; $display("FAIL ovf_newest: got %h exp %h", got, 32'd64); end
    do_rd(ad(4'hd, 4'h0, 8'h02), got);
    compared++;
    if (got !== 32'd1) begin mismatched++; $display("FAIL ovf_status: got %h exp %h", got, 32'd1); end
    do_wr(ad(4'hd, 4'h0, 8'h02), 32'd1);
    do_rd(ad(4'hd, 4'h0, 8'h02), got);
    compared++;
    if (got !== 32'd0) begin mismatched++; $display("FAIL ovf_clear: got %h exp %h", got, 32'd0); end
`else
    do_rd(ad(4'hf, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'd0) begin mismatched++; $display("FAIL drop_oldest: got %h exp %h", got, 32'd0); end
    do_rd(ad(4'hf, 4'h0, 8'h3f), got);
    compared++;
    if (got !== 32'd63) begin mismatched++; $display("FAIL drop_newest: got %h exp %h", got, 32'd63); end
    do_rd(ad(4'hd, 4'h0, 8'h02), got);
    compared++;
    if (got !== 32'd0) begin mismatched++; $display("FAIL drop_status: got %h exp %h", got, 32'd0); end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] got;
    logic [31:0] exp3;
`ifdef NKMD_DAI_RX_OVF_EN
    exp3 = 32'd64;
`else
    exp3 = 32'd63;
`endif
    do_wr(ad(4'hd, 4'h0, 8'h00), 32'd60);
    do_rd(ad(4'hd, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'd4) begin mismatched++; $display("FAIL wrap_cnt4: got %h exp %h", got, 32'd4); end
    for (int i = 0; i < 3; i++) do_ack(1'b0, 24'h000100 + 24'(i));
    do_rd(ad(4'hd, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'd7) begin mismatched++; $display("FAIL wrap_cnt7: got %h exp %h", got, 32'd7); end
    do_rd(ad(4'hf, 4'h0, 8'h03), got);
    compared++;
    if (got !== exp3) begin mismatched++; $display("FAIL wrap_buf3: got %h exp %h", got, exp3); end
    do_rd(ad(4'hf, 4'h0, 8'h04), got);
    compared++;
    if (got !== 32'h100) begin mismatched++; $display("FAIL wrap_buf4: got %h exp %h", got, 32'h100); end
    do_rd(ad(4'hf, 4'h0, 8'h06), got);
    compared++;
    if (got !== 32'h102) begin mismatched++; $display("FAIL wrap_buf6: got %h exp %h", got, 32'h102); end
  endtask

  task automatic test_bad_ch();
    logic [31:0] got;
    do_wr(ad(4'hd, 4'h2, 8'h00), 32'd3);
    do_rd(ad(4'hd, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'd7) begin mismatched++; $display("FAIL badch_nowr: got %h exp %h", got, 32'd7); end
    do_rd(ad(4'hd, 4'h2, 8'h00), got);
    compared++;
    if (got !== 32'd0) begin mismatched++; $display("FAIL badch_cnt: got %h exp %h", got, 32'd0); end
    do_rd(ad(4'hf, 4'h2, 8'h00), got);
    compared++;
    if (got !== 32'd0) begin mismatched++; $display("FAIL badch_buf: got %h exp %h", got, 32'd0); end
    do_rd(ad(4'hd, 4'h0, 8'h01), got);
    compared++;
    if (got !== 32'd0) begin mismatched++; $display("FAIL other_reg: got %h exp %h", got, 32'd0); end
    do_rd(ad(4'h0, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'd0) begin mismatched++; $display("FAIL unmapped: got %h exp %h", got, 32'd0); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] got;
    do_rd(ad(4'hd, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'd7) begin mismatched++; $display("FAIL mid_pre: got %h exp %h", got, 32'd7); end
    // reset rises between clock edges while a sample is being strobed
    @(negedge clk);
    rx_ack_i = 1'b1; rx_ch_i = 1'b0; rx_data_i = 24'h000200;
    #2 rst = 1'b1;
    #1;
    compared++;
    if (data_o !== 32'h0) begin mismatched++; $display("FAIL mid_async: got %h exp %h", data_o, 32'h0); end
    @(posedge clk);
    @(negedge clk);
    rx_ack_i = 1'b0;
    rst      = 1'b0;
    do_rd(ad(4'hd, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'd0) begin mismatched++; $display("FAIL mid_cnt0: got %h exp %h", got, 32'd0); end
    do_rd(ad(4'hd, 4'h1, 8'h00), got);
    compared++;
    if (got !== 32'd0) begin mismatched++; $display("FAIL mid_cnt1: got %h exp %h", got, 32'd0); end
    do_ack(1'b0, 24'h000300);
    do_rd(ad(4'hd, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'd1) begin mismatched++; $display("FAIL mid_resume_cnt: got %h exp %h", got, 32'd1); end
    do_rd(ad(4'hf, 4'h0, 8'h00), got);
    compared++;
    if (got !== 32'h300) begin mismatched++; $display("FAIL mid_resume_buf: got %h exp %h", got, 32'h300); end
  endtask

`ifdef NKMD_DAI_RX_OVF_EN
  task automatic test_ovf_set_wins();
    logic [31:0] got;
    do_reset();
    for (int i = 0; i < 64; i++) do_ack(1'b0, 24'(i));
    @(negedge clk);
    rx_ack_i = 1'b1; rx_ch_i = 1'b0; rx_data_i = 24'h000777;
    addr_i = ad(4'hd, 4'h0, 8'h02); data_i = 32'd1; we_i = 1'b1;
    @(posedge clk);
    #1 rx_ack_i = 1'b0; we_i = 1'b0;
    do_rd(ad(4'hd, 4'h0, 8'h02), got);
    compared++;
    if (got !== 32'd1) begin mismatched++; $display("FAIL ovf_set_wins: got %h exp %h", got, 32'd1); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_consume();
    test_clamp();
    test_same_cycle();
    test_full();
    test_wrap();
    test_bad_ch();
    test_rst_mid();
`ifdef NKMD_DAI_RX_OVF_EN
    test_ovf_set_wins();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nkmd_dai_rx_mc.md
NKMD_DAI_RX_MC -- requirements
Module: nkmd_dai_rx_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning sample width in bits (at most 32).
REQ-002 SHALL have parameter DEPTH_LOG2, default 6, meaning log2 of the per-channel ring depth.
REQ-003 SHALL have parameter NCH, default 2, meaning channel count (1..16).
REQ-004 SHALL have the ports below; clock and reset are listed first.
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data_i  in  DATA_W  incoming sample.
- rx_ch_i  in  max(1,$clog2(NCH))  channel of the incoming sample.
- rx_ack_i  in  1  sample valid, one cycle per sample.
- data_i  in  32  R-bus write data.
- data_o  out  32  R-bus read data, registered.
- addr_i  in  32  R-bus address.
- we_i  in  1  R-bus write strobe.

Function
REQ-005 SHALL keep, per channel, a DEPTH-entry ring, write pointer wp, read pointer rp and unread count cnt; DEPTH=2^DEPTH_LOG2 and cnt is DEPTH_LOG2+1 bits wide, range 0..DEPTH.
REQ-006 SHALL decode addr_i[15:12] as region, addr_i[11:8] as ch and addr_i[7:0] as reg/offset.
REQ-007 On rx_ack_i with rx_ch_i<NCH, SHALL write the sample to ring[rx_ch_i][wp], then increment wp modulo DEPTH and increment cnt.
REQ-008 SHALL ignore rx_ack_i with rx_ch_i>=NCH.
REQ-009 Read of {4'hd,ch,8'h00} SHALL return cnt of ch, zero-extended.
REQ-010 Read of {4'hf,ch,off} SHALL return ring[ch][(rp+off[DEPTH_LOG2-1:0]) mod DEPTH], zero-extended; off is relative to oldest unread sample.
REQ-011 Write of {4'hd,ch,8'h00} SHALL consume n=min(data_i[DEPTH_LOG2:0], cnt) samples: rp+=n mod DEPTH, cnt-=n.
REQ-012 Consume and rx_ack_i on the same channel in the same cycle SHALL give cnt_next = cnt - n + 1, where n is clamped against pre-cycle cnt.
REQ-013 Consume and rx_ack_i on different channels in the same cycle SHALL both take effect independently.
REQ-014 data_o SHALL update one cycle after addr_i with latency 1.
REQ-015 data_o SHALL be 0 for an unmapped address, for ch>=NCH, or for another reg in region 4'hd.
REQ-016 Writes to ch>=NCH SHALL be ignored.
REQ-017 Pointer arithmetic SHALL wrap naturally at DEPTH with no bubble at the wrap point.

Reset
REQ-018 While rst is high, every wp, rp and cnt, every overflow flag, and data_o SHALL be 0.
REQ-019 Ring contents SHALL not be reset.
REQ-020 rx_ack_i asserted during rst SHALL be discarded.
REQ-021 Deasserting rst mid-stream SHALL resume from the empty state.

Configuration
REQ-022 Macro NKMD_DAI_RX_OVF_EN defined SHALL apply this full-ring behaviour: rx_ack_i to a channel with cnt==DEPTH and no same-cycle consume overwrites the oldest sample, advances rp by 1 and holds cnt at DEPTH.
REQ-023 With NKMD_DAI_RX_OVF_EN defined, the same event SHALL also set a sticky ovf[ch] flag.
REQ-024 With NKMD_DAI_RX_OVF_EN defined, read {4'hd,ch,8'h02} SHALL return {31'b0, ovf[ch]}, and write {4'hd,ch,8'h02} with data_i[0]=1 SHALL clear ovf[ch].
REQ-025 If that set and that clear coincide, set SHALL win.
REQ-026 Without NKMD_DAI_RX_OVF_EN, a sample to a full channel SHALL be dropped, all state unchanged, and {4'hd,ch,8'h02} SHALL read 0.

Structure
REQ-027 Package nkmd_dai_pkg SHALL hold region constants NKMD_DAI_REG_REGION=4'hd and NKMD_DAI_RX_BUF_REGION=4'hf.
REQ-028 Package nkmd_dai_pkg SHALL hold reg offsets NKMD_DAI_RX_UNREAD=8'h00 and NKMD_DAI_RX_STATUS=8'h02.
REQ-029 Per-channel pointer/count/overflow logic SHALL live in sub-module nkmd_dai_rx_ring_ctl, instantiated NCH times.
REQ-030 Sample storage SHALL be a single shared array indexed {ch, ptr}.

Verification
REQ-031 Three rx_ack_i on ch1 (0x000011, 0x000022, 0x000033) -> read {d,1,00}=3; reads {f,1,00..02} give 0x11, 0x22, 0x33 one cycle later; ch0 unread=0.
REQ-032 Write {d,1,00} data_i=2 after REQ-031 -> unread=1; {f,1,00} reads 0x33.
REQ-033 Write data_i=5 with cnt=1 -> cnt=0, rp advances by 1 only.
REQ-034 With NKMD_DAI_RX_OVF_EN defined, 65 acks on ch0 (values 0..64) -> cnt=64, {f,0,00}=1, status=1; write status 1 -> status=0.
REQ-035 Same 65 acks without NKMD_DAI_RX_OVF_EN -> {f,0,00}=0, {f,0,3F}=63, cnt=64.
REQ-036 With cnt=4, consume 1 and ack on the same channel in one cycle -> cnt=4.
REQ-037 Access to ch=2 with NCH=2 -> reads 0, write has no effect.
REQ-038 Assert rst mid-stream -> all counts 0 asynchronously.
